mem_reader: RTL

MEM_READER -- requirements
Module: mem_reader

---
 rtl/mem_reader.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_reader.sv
// mem_reader: streams a block of words from a synchronous-read memory.
// The block is COUNT words long and starts at BASE_ADDR. The address wraps
// from DEPTH_MEM-1 back to 0. Words are buffered in a 2-entry FIFO and leave
// through a valid/ready output. A 16-bit running checksum covers every word
// that transfers.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - synchronous active-low reset
//   start      - request a readback (sampled only in IDLE)
//   base_addr  - first word address, latched on accepted start
//   count      - number of words (0..DEPTH_MEM), latched on accepted start
//   raddr      - read address to the memory
//   rdata      - memory data, valid one cycle after raddr is sampled
//   out_data   - streamed word (FIFO head)
//   out_valid  - out_data valid
//   out_ready  - consumer accepts; transfer on out_valid && out_ready
//   busy       - high from accepted start until done
//   done       - one-cycle completion pulse
//   checksum   - sum of transferred words modulo 2^16
module mem_reader #(
    parameter int WID_MEM   = 9,
    parameter int DEPTH_MEM = 8192,
    parameter int ADDR_W    = 13
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     count,
    output logic [ADDR_W-1:0]   raddr,
    input  logic [WID_MEM-1:0]  rdata,
    output logic [WID_MEM-1:0]  out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic [15:0]         checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [ADDR_W-1:0]    addr_r;
    logic [ADDR_W:0]      remain_r;
    logic                 pend_r;      // a read was issued last cycle; rdata is valid now
    logic [1:0]           fifo_cnt_r;
    logic [WID_MEM-1:0]   fifo0_r;     // head entry
    logic [WID_MEM-1:0]   fifo1_r;
    logic [15:0]          csum_r;

    logic                 accept_s;
    logic                 pop_s;
    logic                 issue_s;
    logic                 last_issue_s;
    logic                 last_xfer_s;
    logic [1:0]           occ_s;

    // The FIFO head drives the output directly, so out_data is stable while stalled.
    assign raddr     = addr_r;
    assign out_data  = fifo0_r;
    assign out_valid = (fifo_cnt_r != 2'd0);
    assign busy      = (state_r == READ) || (state_r == DRAIN);
    assign done      = (state_r == DONE);
    assign checksum  = csum_r;

    // Handshake, issue and completion decode.
    always_comb begin
        accept_s = (state_r == IDLE) && start;
        pop_s    = (fifo_cnt_r != 2'd0) && out_ready;
        // Count a word leaving this cycle as a free slot. This keeps one word
        // per cycle with out_ready held high, and the FIFO never holds more than two.
        occ_s    = fifo_cnt_r + {1'b0, pend_r} - {1'b0, pop_s};
        issue_s  = (state_r == READ) && (occ_s < 2'd2) &&
                   (remain_r != {(ADDR_W+1){1'b0}});
        last_issue_s = issue_s && (remain_r == {{ADDR_W{1'b0}}, 1'b1});
        last_xfer_s  = (state_r == DRAIN) && pop_s && (fifo_cnt_r == 2'd1) && !pend_r;
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (count == {(ADDR_W+1){1'b0}}) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = READ;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ: begin
                if (last_issue_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = READ;
                end
            end
            DRAIN: begin
                if (last_xfer_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Address/remaining counters, read pipeline flag, FIFO and checksum.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_r     <= {ADDR_W{1'b0}};
            remain_r   <= {(ADDR_W+1){1'b0}};
            pend_r     <= 1'b0;
            fifo_cnt_r <= 2'd0;
            fifo0_r    <= {WID_MEM{1'b0}};
            fifo1_r    <= {WID_MEM{1'b0}};
            csum_r     <= 16'd0;
        end else begin
            if (accept_s) begin
                addr_r   <= base_addr;
                remain_r <= count;
            end else if (issue_s) begin
                if (addr_r == ADDR_W'(DEPTH_MEM - 1)) begin
                    addr_r <= {ADDR_W{1'b0}};
                end else begin
                    addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
                remain_r <= remain_r - {{ADDR_W{1'b0}}, 1'b1};
            end

            pend_r <= issue_s;

            // The issue throttle means a push never arrives at a full FIFO unless a pop happens too.
            case ({pend_r, pop_s})
                2'b10: begin
                    if (fifo_cnt_r == 2'd0) begin
                        fifo0_r <= rdata;
                    end else begin
                        fifo1_r <= rdata;
                    end
                    fifo_cnt_r <= fifo_cnt_r + 2'd1;
                end
                2'b01: begin
                    fifo0_r    <= fifo1_r;
                    fifo_cnt_r <= fifo_cnt_r - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt_r == 2'd1) begin
                        fifo0_r <= rdata;
                    end else begin
                        fifo0_r <= fifo1_r;
                        fifo1_r <= rdata;
                    end
                end
                default: begin
                    fifo_cnt_r <= fifo_cnt_r;
                end
            endcase

            if (accept_s) begin
                csum_r <= 16'd0;
            end else if (pop_s) begin
                csum_r <= csum_r + 16'(fifo0_r);
            end
        end
    end

endmodule
